// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the MIPS datapath load/store port. Models a
// word-organised data RAM behind a valid/ready request and response
// handshake, with a programmable number of wait states, fault reporting for
// misaligned or out-of-range addresses, and a stall output that freezes the
// single-cycle core while an access is in flight.
//
// Ports
//   clk        in   1   rising-edge clock
//   arst_n     in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   request can be accepted (IDLE only)
//   req_write  in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data
//   req_be     in   4   byte enables, bit i -> byte [8i+7:8i] (stores only)
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   consumer takes the response
//   rsp_rdata  out  32  load data, 0 for stores and faults
//   rsp_err    out  1   misaligned or out-of-range address
//   stall      out  1   hold the core's PC and register writes
//
// FSM
//   state  | meaning
//   IDLE   | ready for a request; accept on req_valid
//   WAIT   | wait states counting down; array access when counter hits 0
//   RESP   | response presented, held until rsp_ready
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int              CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int              AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CW-1:0]   CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [31:0]     DEPTH_U  = DEPTH_WORDS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [CW-1:0]  r_cnt;
    logic           r_write;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_wdata;
    logic [3:0]     r_be;
    logic [31:0]    r_rdata;
    logic           r_err;

    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_accept;
    logic           w_fault;
    logic           w_access_now;
    logic           w_access_late;
    logic           w_access;
    logic           w_acc_write;
    logic [AW-1:0]  w_acc_idx;
    logic [31:0]    w_acc_wdata;
    logic [3:0]     w_acc_be;
    logic           w_mem_we;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept = req_valid & (r_state == S_IDLE);
    assign w_fault  = (req_addr[1:0] != 2'b00) | ({2'b00, req_addr[31:2]} >= DEPTH_U);

    // With zero wait states the array is accessed on the accept edge itself,
    // straight from the request inputs; otherwise from the latched request
    // once the wait counter expires.
    assign w_access_now  = w_accept & ~w_fault & (WAIT_CYCLES == 0);
    assign w_access_late = (r_state == S_WAIT) & (r_cnt == '0);
    assign w_access      = w_access_now | w_access_late;

    assign w_acc_write = w_access_late ? r_write : req_write;
    assign w_acc_idx   = w_access_late ? r_idx   : req_addr[AW+1:2];
    assign w_acc_wdata = w_access_late ? r_wdata : req_wdata;
    assign w_acc_be    = w_access_late ? r_be    : req_be;

    // Gating with arst_n keeps a zero-wait store from slipping into the
    // array while reset is held.
    assign w_mem_we = w_access & w_acc_write & arst_n;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (w_accept) begin
                    if (w_fault || (WAIT_CYCLES == 0)) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                stall     = ~rsp_ready;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_idx   <= req_addr[AW+1:2];
                r_wdata <= req_wdata;
                r_be    <= req_be;
                // The fault flag is latched straight into the response
                // error bit; faulted requests go directly to RESP.
                r_err   <= w_fault;
                r_rdata <= '0;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_access && !w_acc_write) begin
                r_rdata <= r_mem[w_acc_idx];
            end

            if ((r_state == S_RESP) && rsp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data array (not reset); byte-masked store on the access edge only
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_be[b]) begin
                    r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two responders (WAIT_CYCLES=2 and WAIT_CYCLES=0) with independent stimulus.
// A transaction-level model tracks, per instance, whether a request is
// outstanding, the clock at which its response appears, and a word array;
// every cycle out of reset the DUT outputs are compared against it.
// Directed transactions add literal expectations on data and latency.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        req_valid [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        stall     [2];

    int wc [2] = '{2, 0};

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .stall(stall[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .stall(stall[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one outstanding request per instance, response
    // visible from clock m_resp_edge onward, access performed at that clock.
    // ------------------------------------------------------------------
    int          edge_n = 0;
    bit          m_busy      [2] = '{0, 0};
    int          m_resp_edge [2];
    bit          m_fault     [2];
    bit          m_wr        [2];
    int          m_idx       [2];
    logic [31:0] m_wd        [2];
    logic [3:0]  m_be        [2];
    logic [31:0] m_rdata     [2] = '{0, 0};
    bit          m_err       [2] = '{0, 0};
    logic [31:0] m_mem       [2][256];

    always @(posedge clk) begin
        edge_n++;
        if (arst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (m_busy[d] && (edge_n - 1 >= m_resp_edge[d]) && rsp_ready[d]) begin
                    m_busy[d] = 0;
                end else if (!m_busy[d] && req_valid[d] === 1'b1) begin
                    m_busy[d]      = 1;
                    m_fault[d]     = (req_addr[d] % 4 != 0) || (req_addr[d] / 4 >= 256);
                    m_resp_edge[d] = m_fault[d] ? edge_n : edge_n + wc[d];
                    m_wr[d]        = req_write[d];
                    m_idx[d]       = m_fault[d] ? 0 : int'(req_addr[d] / 4);
                    m_wd[d]        = req_wdata[d];
                    m_be[d]        = req_be[d];
                    m_rdata[d]     = 0;
                    m_err[d]       = 0;
                end
                if (m_busy[d] && edge_n == m_resp_edge[d]) begin
                    if (m_fault[d]) begin
                        m_err[d] = 1;
                    end else if (m_wr[d]) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[d][b]) m_mem[d][m_idx[d]][8*b +: 8] = m_wd[d][8*b +: 8];
                    end else begin
                        m_rdata[d] = m_mem[d][m_idx[d]];
                    end
                end
            end
        end
    end

    always @(negedge arst_n) begin
        for (int d = 0; d < 2; d++) m_busy[d] = 0;
    end

    always @(negedge clk) begin
        if (arst_n) begin
            for (int d = 0; d < 2; d++) begin
                bit ev;
                ev = m_busy[d] && (edge_n >= m_resp_edge[d]);
                chk($sformatf("dut%0d rsp_valid", d), rsp_valid[d], ev);
                chk($sformatf("dut%0d req_ready", d), req_ready[d], !m_busy[d]);
                chk($sformatf("dut%0d stall", d), stall[d],
                    (req_valid[d] && !m_busy[d]) || (m_busy[d] && !ev) || (ev && !rsp_ready[d]));
                chk($sformatf("dut%0d rsp_rdata", d), rsp_rdata[d], ev ? m_rdata[d] : 32'h0);
                chk($sformatf("dut%0d rsp_err", d), rsp_err[d], ev ? m_err[d] : 1'b0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed transaction; entered and left at posedge+1
    // ------------------------------------------------------------------
    task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        int          t_acc;
        bit          ok;
        logic [31:0] r0;
        logic        e0;
        rd  = 32'hx;
        er  = 1'bx;
        lat = -1;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        req_be[d]    = be;
        rsp_ready[d] = (hold == 0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin ok = 1; break; end
        end
        if (!ok) begin
            timeout_fail($sformatf("dut%0d accept", d));
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        t_acc = edge_n;
        req_valid[d] = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin ok = 1; break; end
        end
        if (!ok) begin
            timeout_fail($sformatf("dut%0d response", d));
            rsp_ready[d] = 1'b1;
            @(posedge clk); #1;
            return;
        end
        lat = edge_n - t_acc + 1;
        rd  = rsp_rdata[d];
        er  = rsp_err[d];
        if (hold > 0) begin
            r0 = rd;
            e0 = er;
            for (int i = 1; i < hold; i++) begin
                @(negedge clk);
                chk($sformatf("dut%0d hold rsp_valid", d), rsp_valid[d], 1'b1);
                chk($sformatf("dut%0d hold rdata", d), rsp_rdata[d], r0);
                chk($sformatf("dut%0d hold err", d), rsp_err[d], e0);
                chk($sformatf("dut%0d hold req_ready", d), req_ready[d], 1'b0);
                chk($sformatf("dut%0d hold stall", d), stall[d], 1'b1);
            end
            @(posedge clk); #1;
            rsp_ready[d] = 1'b1;
            @(negedge clk);
            chk($sformatf("dut%0d handshake stall", d), stall[d], 1'b0);
            chk($sformatf("dut%0d handshake rsp_valid", d), rsp_valid[d], 1'b1);
            @(posedge clk); #1;
            chk($sformatf("dut%0d post rsp_valid", d), rsp_valid[d], 1'b0);
            chk($sformatf("dut%0d post req_ready", d), req_ready[d], 1'b1);
            chk($sformatf("dut%0d post rdata", d), rsp_rdata[d], 32'h0);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d rsp_valid", tag, d), rsp_valid[d], 1'b0);
            chk($sformatf("%s dut%0d req_ready", tag, d), req_ready[d], 1'b1);
            chk($sformatf("%s dut%0d stall", tag, d), stall[d], 1'b0);
            chk($sformatf("%s dut%0d rsp_rdata", tag, d), rsp_rdata[d], 32'h0);
            chk($sformatf("%s dut%0d rsp_err", tag, d), rsp_err[d], 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          kind;

        arst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_be[d] = '0;      rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Known contents for words 0..31
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++)
                txn(d, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, 0, rd, er, lat);

        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, rd, er, lat);
            chk($sformatf("dut%0d store latency", d), lat, wc[d] + 1);
            chk($sformatf("dut%0d store rdata", d), rd, 32'h0);
            txn(d, 1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat);
            chk($sformatf("dut%0d load 0x10", d), rd, 32'hDEAD_BEEF);
            chk($sformatf("dut%0d load latency", d), lat, wc[d] + 1);

            txn(d, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, rd, er, lat);
            txn(d, 1'b0, 32'h10, 32'h0, 4'b1111, 0, rd, er, lat);
            chk($sformatf("dut%0d partial store", d), rd, 32'hDE22_BE44);

            txn(d, 1'b0, 32'h12, 32'h0, 4'b1111, 0, rd, er, lat);
            chk($sformatf("dut%0d misaligned err", d), er, 1'b1);
            chk($sformatf("dut%0d misaligned rdata", d), rd, 32'h0);
            chk($sformatf("dut%0d fault latency", d), lat, 1);
            txn(d, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'b1111, 0, rd, er, lat);
            chk($sformatf("dut%0d range err", d), er, 1'b1);
            chk($sformatf("dut%0d range latency", d), lat, 1);
            txn(d, 1'b0, 32'h0, 32'h0, 4'b0000, 0, rd, er, lat);
            chk($sformatf("dut%0d load 0x0", d), rd, 32'hA500_0000);
            chk($sformatf("dut%0d load 0x0 err", d), er, 1'b0);

            txn(d, 1'b0, 32'h10, 32'h0, 4'b0000, 5, rd, er, lat);
            chk($sformatf("dut%0d held load", d), rd, 32'hDE22_BE44);
        end

        // Reset pulse while the WAIT_CYCLES=2 store is waiting
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h55; req_be[0] = 4'hF; rsp_ready[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #1;
        chk("dut0 wait stall", stall[0], 1'b1);
        chk("dut0 wait rsp_valid", rsp_valid[0], 1'b0);
        arst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk); #1;
        chk_reset_outputs("reset held");
        @(negedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("dut0 discarded store", rd, 32'hA500_0008);
        txn(1, 1'b1, 32'h20, 32'h55, 4'hF, 0, rd, er, lat);
        chk("dut1 store 0x20 latency", lat, 1);
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("dut1 load 0x20", rd, 32'h55);

        // Randomized traffic, checked cycle by cycle against the model
        repeat (3000) begin
            for (int d = 0; d < 2; d++) begin
                req_valid[d] = 1'($urandom_range(0, 1));
                req_write[d] = 1'($urandom_range(0, 1));
                kind = int'($urandom_range(0, 9));
                if (kind < 7)
                    req_addr[d] = 32'($urandom_range(0, 31) * 4);
                else if (kind < 9)
                    req_addr[d] = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
                else
                    req_addr[d] = 32'($urandom_range(256, 4000) * 4);
                req_wdata[d] = $urandom;
                req_be[d]    = 4'($urandom_range(0, 15));
                rsp_ready[d] = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
